// File: rtl/tamagotchi_pkg.sv
// Shared constants for the tamagotchi drive-side timers: FSM encoding,
// default millisecond prescale and a counter-width helper.
package tamagotchi_pkg;

  localparam int unsigned CLKS_PER_MS_DEF = 50000;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ON       = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;

  // $clog2 returns 0 for n<=1; counters still need at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/humidificador_ctrl_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CLKS_PER_MS cycles, phase
// restarted by clr so the first tick lands exactly CLKS_PER_MS cycles later.
module ms_tick
  import tamagotchi_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = CLKS_PER_MS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     PW   = cnt_width(CLKS_PER_MS);
  localparam logic [PW-1:0]   LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/humidificador_ctrl.sv
// Timed pump driver: holds ouhum high for dur_ms milliseconds, then enforces
// COOLDOWN_MS of off-time before another burst request is accepted.
module humidificador_ctrl
  import tamagotchi_pkg::*;
#(
  parameter int unsigned CLKS_PER_MS = CLKS_PER_MS_DEF,
  parameter int unsigned COOLDOWN_MS = 2000,
  parameter int unsigned DUR_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DUR_W-1:0] dur_ms,
  input  logic             abort,
  output logic             ouhum,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW          = cnt_width(COOLDOWN_MS + 1);
  localparam logic [CW-1:0] CD_LAST     = CW'((COOLDOWN_MS == 0) ? 0 : COOLDOWN_MS - 1);
  localparam logic [1:0]    ST_AFTER_ON = (COOLDOWN_MS == 0) ? ST_IDLE : ST_COOLDOWN;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [DUR_W-1:0] r_dur;
  logic [DUR_W-1:0] r_ms_cnt;
  logic [CW-1:0]    r_cd_cnt;
  logic             r_ouhum;
  logic             r_busy;
  logic             r_done;
  logic             w_tick;
  logic             w_accept;
  logic             w_on_end;
  logic             w_cd_end;
  logic             w_clr;

  // Expiry is decided on the tick that completes the last millisecond, so the
  // output drops on exactly the dur_ms*CLKS_PER_MS-th edge after acceptance.
  assign w_accept = (r_state == ST_IDLE) && start && (dur_ms != '0);
  assign w_on_end = (r_state == ST_ON) && (abort || (w_tick && (r_ms_cnt == r_dur - 1'b1)));
  assign w_cd_end = (r_state == ST_COOLDOWN) && w_tick && (r_cd_cnt == CD_LAST);
  assign w_clr    = w_accept || w_on_end;

  ms_tick #(
    .CLKS_PER_MS (CLKS_PER_MS)
  ) u_ms_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept) w_state_next = ST_ON;
      ST_ON:       if (w_on_end) w_state_next = ST_AFTER_ON;
      ST_COOLDOWN: if (w_cd_end) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_dur    <= '0;
      r_ms_cnt <= '0;
      r_cd_cnt <= '0;
      r_ouhum  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ouhum <= (w_state_next == ST_ON);
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= w_on_end;

      if (w_accept) begin
        r_dur    <= dur_ms;
        r_ms_cnt <= '0;
      end else if ((r_state == ST_ON) && w_tick) begin
        r_ms_cnt <= r_ms_cnt + 1'b1;
      end

      if (w_on_end) begin
        r_cd_cnt <= '0;
      end else if ((r_state == ST_COOLDOWN) && w_tick) begin
        r_cd_cnt <= r_cd_cnt + 1'b1;
      end
    end
  end

  assign ouhum = r_ouhum;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_humidificador_ctrl.sv
// Directed bench for humidificador_ctrl with CLKS_PER_MS=4, DUR_W=12;
// u_dut uses COOLDOWN_MS=2, u_dut0 uses COOLDOWN_MS=0.
module tb_humidificador_ctrl;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort, start0, abort0;
  logic [DW-1:0] dur_ms, dur0;
  logic          ouhum, busy, done;
  logic          ouhum0, busy0, done0;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt, dones, acc;

  always #5 clk = ~clk;

  humidificador_ctrl #(.CLKS_PER_MS(4), .COOLDOWN_MS(2), .DUR_W(DW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dur_ms(dur_ms), .abort(abort),
    .ouhum(ouhum), .busy(busy), .done(done)
  );

  humidificador_ctrl #(.CLKS_PER_MS(4), .COOLDOWN_MS(0), .DUR_W(DW)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .dur_ms(dur0), .abort(abort0),
    .ouhum(ouhum0), .busy(busy0), .done(done0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; dur_ms = '0;
    start0 = 1'b0; abort0 = 1'b0; dur0 = '0;
    step(); step();
    chk("reset_ouhum", ouhum, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b1;
    step();

    // Normal burst, 3 ms -> 12 cycles on, 8 cycles cooldown
    start = 1'b1; dur_ms = 12'd3;
    step();
    start = 1'b0; dur_ms = '0;
    chk("norm_ouhum_on", ouhum, 1);
    chk("norm_busy_on", busy, 1);
    chk("norm_done_low", done, 0);
    cnt = 0;
    while (ouhum && cnt < 100) begin step(); cnt++; end
    chk("norm_on_cycles", cnt, 12);
    chk("norm_done_pulse", done, 1);
    chk("norm_busy_at_end", busy, 1);
    cnt = 0; dones = 0;
    while (busy && cnt < 100) begin step(); cnt++; dones += int'(done); end
    chk("norm_cool_cycles", cnt, 8);
    chk("norm_extra_done", dones, 0);
    chk("norm_ouhum_idle", ouhum, 0);

    // Zero duration is ignored for 20 cycles
    start = 1'b1; dur_ms = '0; acc = 0;
    for (int i = 0; i < 20; i++) begin step(); acc += int'(ouhum) + int'(busy) + int'(done); end
    start = 1'b0;
    chk("zero_dur_quiet", acc, 0);

    // Abort alone in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);

    // Abort on the 5th cycle of a 10 ms burst
    start = 1'b1; dur_ms = 12'd10;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk("abort_pre_ouhum", ouhum, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_ouhum", ouhum, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 1);
    cnt = 0; dones = 0;
    while (busy && cnt < 100) begin step(); cnt++; dones += int'(done); end
    chk("abort_cool_cycles", cnt, 8);
    chk("abort_extra_done", dones, 0);

    // Start+abort together in IDLE: start wins; later starts while busy ignored
    start = 1'b1; abort = 1'b1; dur_ms = 12'd2;
    step();
    start = 1'b0; abort = 1'b0; dur_ms = 12'd5;
    chk("start_abort_ouhum", ouhum, 1);
    cnt = 0;
    while (ouhum && cnt < 100) begin start = (cnt == 2); step(); cnt++; end
    start = 1'b0;
    chk("busy_start_on_cycles", cnt, 8);
    cnt = 0;
    while (busy && cnt < 100) begin start = (cnt == 3); step(); cnt++; end
    start = 1'b0;
    chk("busy_start_cool_cycles", cnt, 8);
    step();
    chk("busy_start_not_queued", busy, 0);

    // Held start: re-accepted on the first cycle after busy drops
    start = 1'b1; dur_ms = 12'd1;
    step();
    cnt = 0;
    while (busy && cnt < 100) begin step(); cnt++; end
    chk("held_busy_cycles", cnt, 12);
    step();
    start = 1'b0;
    chk("held_reaccept_ouhum", ouhum, 1);
    chk("held_reaccept_busy", busy, 1);
    cnt = 0;
    while (busy && cnt < 100) begin step(); cnt++; end
    chk("held_second_len", cnt, 12);

    // Asynchronous reset mid-burst
    start = 1'b1; dur_ms = 12'd10;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_ouhum", ouhum, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    step();
    chk("rst_hold_done", done, 0);
    reset = 1'b1;
    step();
    start = 1'b1; dur_ms = 12'd1;
    step();
    start = 1'b0;
    cnt = 0;
    while (ouhum && cnt < 100) begin step(); cnt++; end
    chk("rst_after_on_cycles", cnt, 4);
    chk("rst_after_done", done, 1);

    // No-cooldown instance: busy and ouhum fall together, back-to-back start
    start0 = 1'b1; dur0 = 12'd2;
    step();
    chk("nocd_ouhum_on", ouhum0, 1);
    cnt = 0;
    while (ouhum0 && cnt < 100) begin step(); cnt++; end
    chk("nocd_on_cycles", cnt, 8);
    chk("nocd_busy_fall", busy0, 0);
    chk("nocd_done", done0, 1);
    step();
    start0 = 1'b0;
    chk("nocd_b2b_ouhum", ouhum0, 1);
    chk("nocd_b2b_busy", busy0, 1);
    cnt = 0;
    while (busy0 && cnt < 100) begin step(); cnt++; end
    chk("nocd_b2b_len", cnt, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
